multicycle_datapath: RTL and testbench
======================================

# multicycle_datapath

Parametrised multicycle successor to the single-cycle RV32I datapath: executes one instruction per 3–5+ cycles under an internal sequencer FSM and talks to separate instruction and data memories over req/ack handshakes, so memories may insert wait states. Decode stays external: a combinational control unit reads `instr` and drives the control inputs. The block adds a real branch target, load/store, write-back and an alignment-fault halt state.

## Interface
- `XLEN`, 32: datapath, PC and register width; 32 or 64.
- `INITIAL_PC`, 32'h00400000: PC value loaded on reset.
- `REGCOUNT`, 32: register count passed to `regfile`.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `iReq` out 1: instruction fetch request. `iAddr` out XLEN: fetch address (= PC). `iAck` in 1: fetch complete. `iData` in 32: fetched word, valid with `iAck`.
- `dReq` out 1, `dWe` out 1, `dAddr` out XLEN, `dWData` out XLEN: data request, write enable, address, store data. `dAck` in 1, `dRData` in XLEN: completion and load data.
- `ALUSrc`, `RegWrite`, `MemToReg`, `MemRead`, `MemWrite`, `Branch` in 1 each; `ALUCtrl` in 4: from external decoder, functions of `instr` only.
- `instr` out 32: latched instruction register.
- `PC` out XLEN; `Zero` out 1; `WriteBackData` out XLEN.
- `retire` out 1: one-cycle pulse in the final state of each instruction.
- `fault` out 1, `faultPC` out XLEN: sticky alignment fault and PC of faulting instruction.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Reset → FETCH.
- FETCH: `iReq`=1, `iAddr`=PC. On edge with `iReq&iAck`: `instr`←`iData`, → DECODE.
- DECODE: A←rs1 (instr[19:15]), B←rs2 (instr[24:20]); IMM←imm_S if `MemWrite`, else imm_I; all sign-extended to XLEN. → EXEC.
- EXEC: codebase `alu` computes A op (ALUSrc ? IMM : B) with `ALUCtrl`; result latched into R, `Zero` latched (R==0).
  - Branch: target T = PC + imm_B (B-type, bit0=0). If `Branch&Zero`: T[1:0]≠0 → HALT; else PC←T, `retire`, → FETCH. Not taken: PC←PC+4, `retire`, → FETCH.
  - `MemRead|MemWrite`: R[1:0]≠0 → HALT (no `dReq` issued); else → MEM.
  - Otherwise → WB.
- MEM: `dReq`=1, `dAddr`=R, `dWe`=`MemWrite`, `dWData`=B. On `dReq&dAck`: load → latch `dRData` into L, → WB; store → PC←PC+4, `retire`, → FETCH.
- WB: `WriteBackData` = `MemToReg` ? L : R; written to rd (instr[11:7]) if `RegWrite` and rd≠0 (x0 writes suppressed here); PC←PC+4, `retire`, → FETCH.
- HALT: `fault`=1, `faultPC`=PC of offending instruction; no requests, no register writes; held until `rst`.
- Arithmetic: PC+4 and PC+imm wrap mod 2^XLEN.

## Timing
- Reset values: PC=INITIAL_PC, `instr`=0, `Zero`=0, `WriteBackData`=0, `retire`=0, `fault`=0, `faultPC`=0, `iReq`=`dReq`=`dWe`=0 while `rst`=1; `dAddr`/`dWData`=0.
- `iReq`/`dReq` are state decodes; address/data/`dWe` stable while request high. Ack sampled only on edges where the matching req is high; ack in the same cycle as req is legal (zero-wait). Acks with req low are ignored.
- Zero-wait latency (cycles, FETCH→next FETCH): branch 3, ALU 4, store 4, load 5; each wait-state cycle adds 1.
- Register write and PC update occur on the same edge that ends WB/EXEC/MEM; `retire` high during that final cycle.
- `rst` mid-transaction: requests drop asynchronously; outstanding transaction abandoned, no state committed.

## Test plan
- Reset: hold `rst` 3 cycles → PC=32'h00400000, `iReq`=0, `fault`=0; release → `iReq`=1, `iAddr`=32'h00400000 next cycle.
- `addi x5,x0,7`, zero-wait fetch → x5=7 after 4 cycles, `retire` once, PC=32'h00400004.
- `lw x6,8(x5)` with x5=0x100, `dAck` 3 cycles late → `dAddr`=0x108, `dWe`=0, x6=`dRData`, 8 cycles total.
- `beq x1,x2,-8` with x1=x2 → PC=PC−8 in 3 cycles; with x1≠x2 → PC+4, no register write.
- `sw` to address 0x102 → no `dReq`, `fault`=1, `faultPC`=instruction PC, stays HALT until reset.
- Assert `rst` while `iReq` high before `iAck` → `iReq` drops immediately; later `iAck` ignored; PC=INITIAL_PC.

Source files
------------

// File: rtl/multicycle_datapath.sv
// Multicycle RV32I-style datapath: FETCH/DECODE/EXEC/MEM/WB sequencer over req/ack instruction and data ports.
// Latency: branch 3, ALU 4, store 4, load 5 cycles plus memory wait states; stalls in FETCH/MEM until ack.

module alu #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [3:0]      ctrl_i,
    output logic [XLEN-1:0] y_o,
    output logic            zero_o
);
    localparam int unsigned SW = $clog2(XLEN);

    logic [SW-1:0] shamt;
    assign shamt = b_i[SW-1:0];

    always_comb begin
        y_o = '0;
        case (ctrl_i)
            4'b0000: y_o = a_i & b_i;
            4'b0001: y_o = a_i | b_i;
            4'b0010: y_o = a_i + b_i;
            4'b0011: y_o = a_i ^ b_i;
            4'b0100: y_o = a_i << shamt;
            4'b0101: y_o = a_i >> shamt;
            4'b1101: y_o = $signed(a_i) >>> shamt;
            4'b0110: y_o = a_i - b_i;
            4'b0111: y_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            4'b1000: y_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            4'b1100: y_o = ~(a_i | b_i);
            default: y_o = '0;
        endcase
    end

    assign zero_o = (y_o == '0);
endmodule

module regfile #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned REGCOUNT = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      ra1_i,
    input  logic [4:0]      ra2_i,
    input  logic [4:0]      wa_i,
    input  logic            we_i,
    input  logic [XLEN-1:0] wd_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o
);
    localparam int unsigned AW = $clog2(REGCOUNT);

    logic [XLEN-1:0] regs_q [REGCOUNT];

    // x0 and indices beyond REGCOUNT always read as zero
    assign rd1_o = (ra1_i != 5'd0 && {27'd0, ra1_i} < REGCOUNT) ? regs_q[ra1_i[AW-1:0]] : '0;
    assign rd2_o = (ra2_i != 5'd0 && {27'd0, ra2_i} < REGCOUNT) ? regs_q[ra2_i[AW-1:0]] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(REGCOUNT); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && wa_i != 5'd0 && {27'd0, wa_i} < REGCOUNT) begin
            regs_q[wa_i[AW-1:0]] <= wd_i;
        end
    end
endmodule

module multicycle_datapath #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] INITIAL_PC = 'h00400000,
    parameter int unsigned     REGCOUNT   = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            iReq,
    output logic [XLEN-1:0] iAddr,
    input  logic            iAck,
    input  logic [31:0]     iData,
    output logic            dReq,
    output logic            dWe,
    output logic [XLEN-1:0] dAddr,
    output logic [XLEN-1:0] dWData,
    input  logic            dAck,
    input  logic [XLEN-1:0] dRData,
    input  logic            ALUSrc,
    input  logic            RegWrite,
    input  logic            MemToReg,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic            Branch,
    input  logic [3:0]      ALUCtrl,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] PC,
    output logic            Zero,
    output logic [XLEN-1:0] WriteBackData,
    output logic            retire,
    output logic            fault,
    output logic [XLEN-1:0] faultPC
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [XLEN-1:0] r_q, r_d, l_q, l_d;
    logic            zero_q, zero_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] fault_pc_q, fault_pc_d;

    logic            ireq_c, dreq_c, dwe_c, retire_c, rf_we_c;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic [XLEN-1:0] imm_i, imm_s, imm_b;
    logic [XLEN-1:0] alu_b, alu_y;
    logic            alu_zero;
    logic [XLEN-1:0] pc_plus4, br_target;
    logic [4:0]      rd_idx;

    assign imm_i     = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
    assign imm_s     = {{(XLEN-12){instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
    assign imm_b     = {{(XLEN-13){instr_q[31]}}, instr_q[31], instr_q[7],
                        instr_q[30:25], instr_q[11:8], 1'b0};
    assign pc_plus4  = pc_q + XLEN'(4);
    assign br_target = pc_q + imm_b;
    assign alu_b     = ALUSrc ? imm_q : b_q;
    assign rd_idx    = instr_q[11:7];

    alu #(.XLEN(XLEN)) u_alu (
        .a_i    (a_q),
        .b_i    (alu_b),
        .ctrl_i (ALUCtrl),
        .y_o    (alu_y),
        .zero_o (alu_zero)
    );

    regfile #(.XLEN(XLEN), .REGCOUNT(REGCOUNT)) u_rf (
        .clk   (clk),
        .rst   (rst),
        .ra1_i (instr_q[19:15]),
        .ra2_i (instr_q[24:20]),
        .wa_i  (rd_idx),
        .we_i  (rf_we_c),
        .wd_i  (WriteBackData),
        .rd1_o (rs1_data),
        .rd2_o (rs2_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= INITIAL_PC;
            instr_q    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            imm_q      <= '0;
            r_q        <= '0;
            l_q        <= '0;
            zero_q     <= 1'b0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            a_q        <= a_d;
            b_q        <= b_d;
            imm_q      <= imm_d;
            r_q        <= r_d;
            l_q        <= l_d;
            zero_q     <= zero_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        a_d        = a_q;
        b_d        = b_q;
        imm_d      = imm_q;
        r_d        = r_q;
        l_d        = l_q;
        zero_d     = zero_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        ireq_c     = 1'b0;
        dreq_c     = 1'b0;
        dwe_c      = 1'b0;
        retire_c   = 1'b0;
        rf_we_c    = 1'b0;

        case (state_q)
            S_FETCH: begin
                ireq_c = 1'b1;
                if (iAck) begin
                    instr_d = iData;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rs1_data;
                b_d     = rs2_data;
                imm_d   = MemWrite ? imm_s : imm_i;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                r_d    = alu_y;
                zero_d = alu_zero;
                if (Branch) begin
                    if (alu_zero && br_target[1:0] != 2'b00) begin
                        state_d    = S_HALT;
                        fault_d    = 1'b1;
                        fault_pc_d = pc_q;
                    end else begin
                        pc_d     = alu_zero ? br_target : pc_plus4;
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end
                end else if (MemRead || MemWrite) begin
                    // Misaligned word access halts before any data request goes out
                    if (alu_y[1:0] != 2'b00) begin
                        state_d    = S_HALT;
                        fault_d    = 1'b1;
                        fault_pc_d = pc_q;
                    end else begin
                        state_d = S_MEM;
                    end
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dreq_c = 1'b1;
                dwe_c  = MemWrite;
                if (dAck) begin
                    if (MemWrite) begin
                        pc_d     = pc_plus4;
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        l_d     = dRData;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we_c  = RegWrite;
                pc_d     = pc_plus4;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Gating with rst drops requests asynchronously, mid-transaction included
    assign iReq          = ireq_c & ~rst;
    assign dReq          = dreq_c & ~rst;
    assign dWe           = dwe_c & ~rst;
    assign retire        = retire_c & ~rst;
    assign iAddr         = pc_q;
    assign dAddr         = r_q;
    assign dWData        = b_q;
    assign instr         = instr_q;
    assign PC            = pc_q;
    assign Zero          = zero_q;
    assign WriteBackData = MemToReg ? l_q : r_q;
    assign fault         = fault_q;
    assign faultPC       = fault_pc_q;
endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: bench-side decoder and memory handshakes, vector table plus reset/halt sequences.
module tb_multicycle_datapath;
    localparam logic [31:0] IPC = 32'h00400000;

    logic        clk, rst;
    logic        iReq, iAck, dReq, dWe, dAck;
    logic [31:0] iAddr, iData, dAddr, dWData, dRData;
    logic        ALUSrc, RegWrite, MemToReg, MemRead, MemWrite, Branch;
    logic [3:0]  ALUCtrl;
    logic [31:0] instr, PC, WriteBackData, faultPC;
    logic        Zero, retire, fault;

    int total  = 0;
    int passed = 0;

    multicycle_datapath dut (
        .clk(clk), .rst(rst),
        .iReq(iReq), .iAddr(iAddr), .iAck(iAck), .iData(iData),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWData(dWData), .dAck(dAck), .dRData(dRData),
        .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemToReg(MemToReg), .MemRead(MemRead),
        .MemWrite(MemWrite), .Branch(Branch), .ALUCtrl(ALUCtrl),
        .instr(instr), .PC(PC), .Zero(Zero), .WriteBackData(WriteBackData),
        .retire(retire), .fault(fault), .faultPC(faultPC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External decoder: addi, add/sub, lw, sw, beq
    always_comb begin
        ALUSrc = 1'b0; RegWrite = 1'b0; MemToReg = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; Branch = 1'b0; ALUCtrl = 4'b0010;
        case (instr[6:0])
            7'b0010011: begin ALUSrc = 1'b1; RegWrite = 1'b1; end
            7'b0110011: begin RegWrite = 1'b1; ALUCtrl = instr[30] ? 4'b0110 : 4'b0010; end
            7'b0000011: begin ALUSrc = 1'b1; RegWrite = 1'b1; MemToReg = 1'b1; MemRead = 1'b1; end
            7'b0100011: begin ALUSrc = 1'b1; MemWrite = 1'b1; end
            7'b1100011: begin Branch = 1'b1; ALUCtrl = 4'b0110; end
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic exec(input logic [31:0] ins, input int iw, input int dw, input logic [31:0] rdat,
                        output int cyc, output bit saw_d, output logic [31:0] da, output bit dwe_s,
                        output logic [31:0] dwd, output logic [31:0] wb, output bit ret, output bit flt);
        int icnt = 0;
        int dcnt = 0;
        cyc = 0; saw_d = 0; da = 0; dwe_s = 0; dwd = 0; wb = 0; ret = 0; flt = 0;
        iData = ins; dRData = rdat;
        while (!ret && !flt && cyc < 40) begin
            @(negedge clk);
            cyc++;
            iAck = 1'b0; dAck = 1'b0;
            if (iReq) begin
                if (icnt == iw) iAck = 1'b1;
                icnt++;
            end
            if (dReq) begin
                saw_d = 1; da = dAddr; dwe_s = dWe; dwd = dWData;
                if (dcnt == dw) dAck = 1'b1;
                dcnt++;
            end
            #1;
            if (retire) begin ret = 1; wb = WriteBackData; end
            if (fault) flt = 1;
        end
        @(posedge clk);
        #1;
        iAck = 1'b0; dAck = 1'b0;
    endtask

    typedef struct {
        logic [31:0] ins;
        int          iw;
        int          dw;
        logic [31:0] rdata;
        int          cyc;
        logic [31:0] pc;
        bit          dreq;
        logic [31:0] daddr;
        bit          dwe;
        logic [31:0] dwd;
        bit          chk_wb;
        logic [31:0] wb;
        bit          zero;
        bit          flt;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          cyc;
        bit          saw_d, dwe_s, ret, flt;
        logic [31:0] da, dwd, wb;
        int          busy;

        //          ins           iw dw rdata         cyc pc           dreq daddr  dwe dwd           chkwb wb            z  flt
        vecs[0]  = '{32'h00700293, 0, 0, 32'h0,        4, 32'h00400004, 0, 32'h0,   0, 32'h0,        1, 32'h7,        0, 0}; // addi x5,x0,7
        vecs[1]  = '{32'h00502023, 0, 0, 32'h0,        4, 32'h00400008, 1, 32'h0,   1, 32'h7,        0, 32'h0,        1, 0}; // sw x5,0(x0)
        vecs[2]  = '{32'h10000293, 1, 0, 32'h0,        5, 32'h0040000C, 0, 32'h0,   0, 32'h0,        1, 32'h100,      0, 0}; // addi x5,x0,0x100
        vecs[3]  = '{32'h0082A303, 0, 3, 32'hCAFEF00D, 8, 32'h00400010, 1, 32'h108, 0, 32'h0,        1, 32'hCAFEF00D, 0, 0}; // lw x6,8(x5)
        vecs[4]  = '{32'h00602223, 0, 1, 32'h0,        5, 32'h00400014, 1, 32'h4,   1, 32'hCAFEF00D, 0, 32'h0,        0, 0}; // sw x6,4(x0)
        vecs[5]  = '{32'h006283B3, 0, 0, 32'h0,        4, 32'h00400018, 0, 32'h0,   0, 32'h0,        1, 32'hCAFEF10D, 0, 0}; // add x7,x5,x6
        vecs[6]  = '{32'h00528013, 0, 0, 32'h0,        4, 32'h0040001C, 0, 32'h0,   0, 32'h0,        1, 32'h105,      0, 0}; // addi x0,x5,5
        vecs[7]  = '{32'h00002423, 0, 0, 32'h0,        4, 32'h00400020, 1, 32'h8,   1, 32'h0,        0, 32'h0,        0, 0}; // sw x0,8(x0)
        vecs[8]  = '{32'hFE528CE3, 0, 0, 32'h0,        3, 32'h00400018, 0, 32'h0,   0, 32'h0,        0, 32'h0,        1, 0}; // beq x5,x5,-8
        vecs[9]  = '{32'hFE628CE3, 0, 0, 32'h0,        3, 32'h0040001C, 0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 0}; // beq x5,x6,-8
        vecs[10] = '{32'h0052A123, 0, 0, 32'h0,        4, 32'h0040001C, 0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 1}; // sw x5,2(x5)

        rst = 1'b1; iAck = 1'b0; dAck = 1'b0; iData = '0; dRData = '0;
        repeat (3) @(negedge clk);
        chk("rst_pc", PC, IPC);
        chk("rst_ireq", {31'd0, iReq}, 32'd0);
        chk("rst_dreq", {31'd0, dReq}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_wbdata", WriteBackData, 32'd0);
        chk("rst_zero", {31'd0, Zero}, 32'd0);
        chk("rst_daddr", dAddr, 32'd0);
        chk("rst_faultpc", faultPC, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ireq", {31'd0, iReq}, 32'd1);
        chk("rel_iaddr", iAddr, IPC);

        for (int v = 0; v < 11; v++) begin
            exec(vecs[v].ins, vecs[v].iw, vecs[v].dw, vecs[v].rdata, cyc, saw_d, da, dwe_s, dwd, wb, ret, flt);
            chk($sformatf("v%0d_cycles", v), cyc, vecs[v].cyc);
            chk($sformatf("v%0d_pc", v), PC, vecs[v].pc);
            chk($sformatf("v%0d_dreq", v), {31'd0, saw_d}, {31'd0, vecs[v].dreq});
            if (vecs[v].dreq) begin
                chk($sformatf("v%0d_daddr", v), da, vecs[v].daddr);
                chk($sformatf("v%0d_dwe", v), {31'd0, dwe_s}, {31'd0, vecs[v].dwe});
                chk($sformatf("v%0d_dwdata", v), dwd, vecs[v].dwd);
            end
            if (vecs[v].chk_wb) chk($sformatf("v%0d_wbdata", v), wb, vecs[v].wb);
            chk($sformatf("v%0d_zero", v), {31'd0, Zero}, {31'd0, vecs[v].zero});
            chk($sformatf("v%0d_fault", v), {31'd0, fault}, {31'd0, vecs[v].flt});
            chk($sformatf("v%0d_retire", v), {31'd0, ret}, {31'd0, !vecs[v].flt});
        end

        // HALT holds: acks with no request are ignored
        busy = 0;
        iData = 32'h00700293;
        repeat (6) begin
            @(negedge clk);
            iAck = 1'b1; dAck = 1'b1;
            #1;
            if (iReq || dReq || retire) busy++;
        end
        @(negedge clk);
        iAck = 1'b0; dAck = 1'b0;
        chk("halt_no_activity", busy, 0);
        chk("halt_faultpc", faultPC, 32'h0040001C);
        chk("halt_pc", PC, 32'h0040001C);
        chk("halt_instr", instr, 32'h0052A123);
        chk("halt_fault", {31'd0, fault}, 32'd1);

        rst = 1'b1;
        @(negedge clk);
        chk("rst2_fault", {31'd0, fault}, 32'd0);
        chk("rst2_faultpc", faultPC, 32'd0);
        chk("rst2_pc", PC, IPC);
        rst = 1'b0;

        // beq x0,x0,+2: taken to a misaligned target
        exec(32'h00000163, 0, 0, 32'h0, cyc, saw_d, da, dwe_s, dwd, wb, ret, flt);
        chk("brmis_fault", {31'd0, flt}, 32'd1);
        chk("brmis_retire", {31'd0, ret}, 32'd0);
        chk("brmis_faultpc", faultPC, IPC);
        chk("brmis_pc", PC, IPC);

        // Reset in the middle of an unacknowledged fetch
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_ireq_before", {31'd0, iReq}, 32'd1);
        #2 rst = 1'b1;
        #1 chk("mid_ireq_drop", {31'd0, iReq}, 32'd0);
        iData = 32'h00700293; iAck = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_instr", instr, 32'd0);
        chk("mid_pc", PC, IPC);
        iAck = 1'b0;
        rst = 1'b0;
        exec(32'h00700293, 0, 0, 32'h0, cyc, saw_d, da, dwe_s, dwd, wb, ret, flt);
        chk("post_cycles", cyc, 4);
        chk("post_wb", wb, 32'd7);
        chk("post_pc", PC, 32'h00400004);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
